// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - round-robin three-port arbiter for the multiplexed RTC address/data bus
module rtc_bus_arbiter #(
    parameter int HOLD = 5,
    parameter int GAP  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  rnw,
    input  logic [23:0] addr,
    input  logic [23:0] wdata,
    input  logic [7:0]  ADin,
    output logic        ad,
    output logic        cs,
    output logic        wr,
    output logic        rd,
    output logic [7:0]  ADout,
    output logic        ad_oe,
    output logic [7:0]  rdata,
    output logic [2:0]  done,
    output logic        busy,
    output logic [2:0]  pend
);
    localparam int DS = 7 + HOLD + GAP;
    localparam int DN = DS + 4 + HOLD;
    localparam int SW = $clog2(DN + 2);

    typedef enum logic [2:0] {IDLE, ADDR, GAPW, DATA, DONE} state_t;

    state_t        state;
    state_t        nxt_state;
    logic [SW-1:0] step;
    logic [1:0]    ptr;
    logic [1:0]    cur;
    logic [1:0]    p1;
    logic [1:0]    p2;
    logic [1:0]    gidx;
    logic          gvalid;
    logic          take;
    logic          cur_rnw;
    logic [7:0]    cur_addr;
    logic [7:0]    cur_wdata;
    logic [2:0]    slot_rnw;
    logic [7:0]    slot_addr [3];
    logic [7:0]    slot_wdata [3];
    int            j;
    logic          ad_on;
    logic          cs_on;
    logic          wr_on;
    logic          rd_on;
    logic          a_drv;
    logic          w_drv;
    logic          rd_sample;
    logic          at_done;

    // First pending port at or after the pointer wins.
    always_comb begin
        p1     = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        p2     = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
        gvalid = 1'b0;
        gidx   = 2'd0;
        if (pend[ptr]) begin
            gvalid = 1'b1;
            gidx   = ptr;
        end else if (pend[p1]) begin
            gvalid = 1'b1;
            gidx   = p1;
        end else if (pend[p2]) begin
            gvalid = 1'b1;
            gidx   = p2;
        end
        take = gvalid && (state == IDLE || state == DONE);
    end

    // Output windows are decoded from the step the counter is about to reach.
    always_comb begin
        j         = int'(step) + 1;
        ad_on     = (j >= 1) && (j < 6 + HOLD);
        cs_on     = ((j >= 2) && (j < 5 + HOLD)) || ((j >= DS) && (j < DS + 3 + HOLD));
        wr_on     = ((j >= 3) && (j < 4 + HOLD)) ||
                    (!cur_rnw && (j >= DS + 1) && (j < DS + 2 + HOLD));
        rd_on     = cur_rnw && (j >= DS + 1) && (j < DS + 2 + HOLD);
        a_drv     = (j >= 4) && (j < 7 + HOLD);
        w_drv     = !cur_rnw && (j >= DS + 2) && (j < DN);
        rd_sample = cur_rnw && (j == DS + 2 + HOLD);
        at_done   = (j == DN);
        if (j < 7 + HOLD)  nxt_state = ADDR;
        else if (j < DS)   nxt_state = GAPW;
        else if (j < DN)   nxt_state = DATA;
        else               nxt_state = DONE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            step      <= '0;
            ptr       <= 2'd0;
            cur       <= 2'd0;
            cur_rnw   <= 1'b0;
            cur_addr  <= 8'h00;
            cur_wdata <= 8'h00;
            slot_rnw  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                slot_addr[i]  <= 8'h00;
                slot_wdata[i] <= 8'h00;
            end
            ad        <= 1'b1;
            cs        <= 1'b1;
            wr        <= 1'b1;
            rd        <= 1'b1;
            ADout     <= 8'hFF;
            ad_oe     <= 1'b0;
            rdata     <= 8'h00;
            done      <= 3'b000;
            busy      <= 1'b0;
            pend      <= 3'b000;
        end else begin
            done <= 3'b000;
            // A request landing on its own grant edge re-arms the slot.
            for (int i = 0; i < 3; i++) begin
                if (req[i] && (!pend[i] || (take && gidx == 2'(i)))) begin
                    pend[i]       <= 1'b1;
                    slot_rnw[i]   <= rnw[i];
                    slot_addr[i]  <= addr[8*i +: 8];
                    slot_wdata[i] <= wdata[8*i +: 8];
                end else if (take && gidx == 2'(i)) begin
                    pend[i] <= 1'b0;
                end
            end
            if (state == IDLE || state == DONE) begin
                busy  <= 1'b0;
                ad    <= 1'b1;
                cs    <= 1'b1;
                wr    <= 1'b1;
                rd    <= 1'b1;
                ADout <= 8'hFF;
                ad_oe <= 1'b0;
                if (take) begin
                    state     <= ADDR;
                    step      <= '0;
                    cur       <= gidx;
                    cur_rnw   <= slot_rnw[gidx];
                    cur_addr  <= slot_addr[gidx];
                    cur_wdata <= slot_wdata[gidx];
                end else begin
                    state <= IDLE;
                end
            end else begin
                step  <= step + 1'b1;
                state <= nxt_state;
                busy  <= 1'b1;
                ad    <= ~ad_on;
                cs    <= ~cs_on;
                wr    <= ~wr_on;
                rd    <= ~rd_on;
                ADout <= a_drv ? cur_addr : (w_drv ? cur_wdata : 8'hFF);
                ad_oe <= a_drv || w_drv;
                if (rd_sample) rdata <= ADin;
                if (at_done) begin
                    done[cur] <= 1'b1;
                    ptr       <= (cur == 2'd2) ? 2'd0 : cur + 2'd1;
                end
            end
        end
    end
endmodule
